// File: rtl/tof_shot_if.sv
// Handshake bundle between system control / trigger chain and the time-of-flight shot timer.
// The master side drives enable and trigger; the slave side (the timer) returns pulse and result.
interface tof_shot_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             trigger;
  logic             fire;
  logic             window_open;
  logic             busy;
  logic [CNT_W-1:0] tof;
  logic             tof_valid;
  logic             timeout;

  modport master (
    output enable, trigger,
    input  fire, window_open, busy, tof, tof_valid, timeout
  );

  modport slave (
    input  enable, trigger,
    output fire, window_open, busy, tof, tof_valid, timeout
  );
endinterface

// File: rtl/tof_shot_timer.sv
// Rangefinder transmit/timing block: fires periodic shots, blanks, listens for the first
// rising trigger edge and reports its shot index, or strobes timeout if the window closes.
module tof_shot_timer #(
  parameter int CNT_W    = 16,
  parameter int PERIOD   = 10000,
  parameter int FIRE_LEN = 4,
  parameter int BLANK    = 20,
  parameter int WINDOW   = 4000
) (
  input  logic     clk,
  input  logic     rst_n,
  tof_shot_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRE   = 3'd1,
    S_BLANK  = 3'd2,
    S_LISTEN = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] K_FIRE_LAST  = CNT_W'(FIRE_LEN - 1);
  localparam logic [CNT_W-1:0] K_BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] K_WIN_LAST   = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] K_PER_LAST   = CNT_W'(PERIOD - 1);
  localparam bit               SKIP_BLANK   = (BLANK == FIRE_LEN);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] k, k_nxt;
  logic             trig_d;
  logic             trig_edge;
  logic             hit, miss, shot_end;
  logic [CNT_W-1:0] tof_q;
  logic             tof_valid_q, timeout_q;

  assign trig_edge = bus.trigger & ~trig_d;
  assign shot_end  = (k == K_PER_LAST);

  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    miss      = 1'b0;
    k_nxt     = k + CNT_W'(1);
    unique case (state)
      S_IDLE:   if (bus.enable) state_nxt = S_FIRE;
      S_FIRE:   if (k == K_FIRE_LAST) state_nxt = SKIP_BLANK ? S_LISTEN : S_BLANK;
      S_BLANK:  if (k == K_BLANK_LAST) state_nxt = S_LISTEN;
      S_LISTEN: begin
        if (trig_edge) begin
          hit       = 1'b1;
          state_nxt = S_HOLD;
        end else if (k == K_WIN_LAST) begin
          miss      = 1'b1;
          state_nxt = S_HOLD;
        end
        // With WINDOW == PERIOD the listen phase runs right up to the shot boundary
        if (shot_end) state_nxt = bus.enable ? S_FIRE : S_IDLE;
      end
      S_HOLD:   if (shot_end) state_nxt = bus.enable ? S_FIRE : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_IDLE || (state_nxt == S_FIRE && state != S_FIRE)) k_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      k           <= '0;
      trig_d      <= 1'b0;
      tof_q       <= '0;
      tof_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      trig_d      <= bus.trigger;
      tof_valid_q <= hit;
      timeout_q   <= miss;
      if (hit) tof_q <= k;
    end
  end

  assign bus.fire        = (state == S_FIRE);
  assign bus.window_open = (state == S_LISTEN);
  assign bus.busy        = (state != S_IDLE);
  assign bus.tof         = tof_q;
  assign bus.tof_valid   = tof_valid_q;
  assign bus.timeout     = timeout_q;

endmodule
